// File: rtl/fifo_downsizer_pkg.sv
// Shared helpers for the FIFO downsizer: lane-count and lane-index width functions.
// Optional beat counter is enabled with FIFO_DOWNSIZER_BEATCNT_EN.
package fifo_downsizer_pkg;

  localparam int BEATCNT_W = 32;

  function automatic int ratio(input int in_w, input int out_w);
    return (out_w > 0) ? (in_w / out_w) : 1;
  endfunction

  // A single-lane configuration still needs a 1-bit counter.
  function automatic int clog2_min1(input int r);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/fifo_downsizer_lane_mux.sv
// Combinational lane select: picks OUT_W-bit lane cnt out of the held IN_W-bit word.
// Lane 0 is the least significant slice.
module fifo_downsizer_lane_mux
  import fifo_downsizer_pkg::*;
#(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32,
  parameter int RATIO = ratio(IN_W, OUT_W),
  parameter int CNT_W = clog2_min1(RATIO)
) (
  input  logic [IN_W-1:0]  hold,
  input  logic [CNT_W-1:0] cnt,
  output logic [OUT_W-1:0] data
);

  // AND-OR mux over all lanes
  always_comb begin
    data = {OUT_W{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      data = data | (hold[i*OUT_W +: OUT_W] & {OUT_W{cnt == CNT_W'(i)}});
    end
  end

endmodule

// File: rtl/fifo_downsizer.sv
// Dequeue-side drain stage: pops IN_W-bit words from a show-ahead FIFO and emits
// RATIO narrow beats per word. Define FIFO_DOWNSIZER_BEATCNT_EN to add beat_cnt.
module fifo_downsizer
  import fifo_downsizer_pkg::*;
#(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             fifo_empty_n,
  input  logic [IN_W-1:0]  fifo_d,
  output logic             fifo_deq,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_first,
  output logic             o_last,
  output logic             idle
`ifdef FIFO_DOWNSIZER_BEATCNT_EN
  ,
  output logic [BEATCNT_W-1:0] beat_cnt
`endif
);

  localparam int RATIO = ratio(IN_W, OUT_W);
  localparam int CNT_W = clog2_min1(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  generate
    if ((IN_W % OUT_W) != 0) begin : g_width_check
      $error("fifo_downsizer: IN_W must be a multiple of OUT_W");
    end
  endgenerate

  logic [IN_W-1:0]  hold_r;
  logic             hold_v_r;
  logic [CNT_W-1:0] cnt_r;
  logic             acc_s;
  logic             done_s;

  // Handshake decode; the pop for the next word overlaps the last beat of this one
  always_comb begin
    acc_s    = hold_v_r & o_ready;
    done_s   = acc_s & (cnt_r == LAST_LANE);
    fifo_deq = fifo_empty_n & ~RST & ~CLR & (~hold_v_r | done_s);
  end

  // Held word, valid flag and lane counter
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      hold_v_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (fifo_deq) begin
      hold_r   <= fifo_d;
      hold_v_r <= 1'b1;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (done_s) begin
      hold_v_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (acc_s) begin
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  fifo_downsizer_lane_mux #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) u_lane_mux (
    .hold (hold_r),
    .cnt  (cnt_r),
    .data (o_data)
  );

  // Stream flags, all derived from registered state
  always_comb begin
    o_valid = hold_v_r;
    o_first = hold_v_r & (cnt_r == {CNT_W{1'b0}});
    o_last  = hold_v_r & (cnt_r == LAST_LANE);
    idle    = ~hold_v_r;
  end

`ifdef FIFO_DOWNSIZER_BEATCNT_EN
  logic [BEATCNT_W-1:0] beat_cnt_r;

  // Saturating count of accepted beats
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      beat_cnt_r <= {BEATCNT_W{1'b0}};
    end else if (acc_s && (beat_cnt_r != {BEATCNT_W{1'b1}})) begin
      beat_cnt_r <= beat_cnt_r + BEATCNT_W'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign beat_cnt = beat_cnt_r;
`endif

endmodule
